shift_sub_divider: RTL

- Sequential restoring divider, unsigned, one quotient bit per clock.
- It is the inverse of the team's shift-add multiplier datapath, and its remainder/quotient register works as a left-shifting A:Q pair.
- Used in the same arithmetic lab datapath, sitting beside the multiplier's product register and its controller.

---
 rtl/arith_pkg.sv | 17 +
 rtl/div_step.sv | 30 +++
 rtl/shift_sub_divider.sv | 124 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: divider FSM states, default width and counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Counter must hold WIDTH itself, hence width+1 values.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract D, restore on borrow.
module div_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   trial;

    always_comb begin
        a_sh  = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
        q_sh  = {q_i[WIDTH-2:0], 1'b0};
        trial = a_sh - {1'b0, d_i};
        // Top bit of the trial difference is the borrow: set means A < D.
        if (!trial[WIDTH]) begin
            a_o = trial;
            q_o = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            a_o = a_sh;
            q_o = q_sh;
        end
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock, with divide-by-zero flag.
module shift_sub_divider
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;
    logic             accept;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .a_i (a_q),
        .q_i (q_q),
        .d_i (d_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    assign accept = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    a_d   = '0;
                    q_d   = dividend;
                    d_d   = divisor;
                    cnt_d = CntW'(WIDTH);
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        // No iterations: publish the flagged result straight away.
                        state_d = DONE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = dividend;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = step_q;
                    rem_d   = step_a[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
